// File: rtl/ms_game_ctrl.sv
// Minesweeper game sequencer: turns user handshakes into one-hot, one-cycle datapath control pulses.
// Optional datapath-wait watchdog with ERR state: define WAIT_TIMEOUT_EN.

module ms_game_ctrl #(
  parameter int DISP_HOLD   = 4,
  parameter int MOVE_W      = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clka,
  input  logic              restart_n,
  input  logic              new_game,
  input  logic              data_valid,
  input  logic              alu_done,
  input  logic              display_done,
  input  logic              gameover,
  input  logic              win,
  output logic              dp_restart,
  output logic              dp_start,
  output logic              dp_load,
  output logic              dp_decode,
  output logic              dp_alu,
  output logic              dp_display,
  output logic              in_ready,
  output logic              in_ack,
  output logic              game_active,
  output logic              game_over_o,
  output logic              game_won_o,
  output logic [MOVE_W-1:0] move_count,
  output logic              ctrl_err
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_START, S_WAIT_IN, S_LOAD, S_DECODE, S_ALU,
    S_ALU_WAIT, S_DISPLAY, S_DISP_WAIT, S_OVER
`ifdef WAIT_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;

  localparam logic [MOVE_W-1:0] MOVE_MAX = '1;

  state_t     state, state_next;
  logic       over_flag, won_flag;
  logic [7:0] hold_cnt;
  logic       disp_exit;

  // The hold counter is sampled before its decrement: a value of 1 means it
  // reaches zero on this edge, so DISP_WAIT lasts exactly DISP_HOLD cycles.
  assign disp_exit = display_done && (hold_cnt <= 8'd1);

`ifdef WAIT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      wd_cnt <= '0;
    end else if (state == S_ALU_WAIT || state == S_DISP_WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  // Watchdog limit is only meaningful when the timeout feature is built in.
  localparam int unused_timeout = TIMEOUT_CYC;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      S_INIT:     state_next = S_IDLE;
      S_IDLE:     if (new_game) state_next = S_START;
      S_START:    state_next = S_WAIT_IN;
      S_WAIT_IN: begin
        if (new_game)        state_next = S_START;
        else if (data_valid) state_next = S_LOAD;
      end
      S_LOAD:     state_next = S_DECODE;
      S_DECODE:   state_next = S_ALU;
      S_ALU:      state_next = S_ALU_WAIT;
      S_ALU_WAIT: begin
        if (alu_done) state_next = S_DISPLAY;
`ifdef WAIT_TIMEOUT_EN
        else if (wd_expired) state_next = S_ERR;
`endif
      end
      S_DISPLAY:  state_next = S_DISP_WAIT;
      S_DISP_WAIT: begin
        if (disp_exit) state_next = over_flag ? S_OVER : S_WAIT_IN;
`ifdef WAIT_TIMEOUT_EN
        else if (wd_expired) state_next = S_ERR;
`endif
      end
      S_OVER:     if (new_game) state_next = S_START;
`ifdef WAIT_TIMEOUT_EN
      S_ERR:      if (new_game) state_next = S_INIT;
`endif
      default:    state_next = S_INIT;
    endcase
  end

  // Game bookkeeping: move counter, latched result flags, display hold timer.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      move_count <= '0;
      over_flag  <= 1'b0;
      won_flag   <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        S_START: begin
          move_count <= '0;
          over_flag  <= 1'b0;
          won_flag   <= 1'b0;
        end
        S_ALU_WAIT: begin
          if (alu_done) begin
            over_flag <= gameover;
            won_flag  <= win;
            if (move_count != MOVE_MAX) move_count <= move_count + 1'b1;
          end
        end
        S_DISPLAY:   hold_cnt <= 8'(DISP_HOLD);
        S_DISP_WAIT: if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    dp_restart  = 1'b0;
    dp_start    = 1'b0;
    dp_load     = 1'b0;
    dp_decode   = 1'b0;
    dp_alu      = 1'b0;
    dp_display  = 1'b0;
    in_ready    = 1'b0;
    in_ack      = 1'b0;
    game_active = 1'b0;
    game_over_o = 1'b0;
    game_won_o  = 1'b0;
    ctrl_err    = 1'b0;
    case (state)
      S_INIT:      dp_restart = 1'b1;
      S_START:     begin dp_start   = 1'b1; game_active = 1'b1; end
      S_WAIT_IN:   begin in_ready   = 1'b1; game_active = 1'b1; end
      S_LOAD:      begin dp_load    = 1'b1; in_ack = 1'b1; game_active = 1'b1; end
      S_DECODE:    begin dp_decode  = 1'b1; game_active = 1'b1; end
      S_ALU:       begin dp_alu     = 1'b1; game_active = 1'b1; end
      S_ALU_WAIT:  game_active = 1'b1;
      S_DISPLAY:   begin dp_display = 1'b1; game_active = 1'b1; end
      S_DISP_WAIT: game_active = 1'b1;
      S_OVER:      begin game_over_o = 1'b1; game_won_o = won_flag; end
`ifdef WAIT_TIMEOUT_EN
      S_ERR:       ctrl_err = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: doc/ms_game_ctrl.md
Name: ms_game_ctrl

Overview:
- Single-clock sequencer for the minesweeper datapath.
- Converts user handshakes into one-cycle control pulses for the datapath: restart, start, load, decode, alu, display.
- Waits on the datapath's alu_done/display_done, then latches the game result.
- Sits between the user-input/button logic and the datapath; it is the only driver of the datapath control inputs.

Parameters:
- DISP_HOLD, 4, minimum cycles spent in DISP_WAIT before leaving; range 1..255.
- MOVE_W, 5, width of move_count; must hold 25.
- TIMEOUT_CYC, 255, watchdog limit in cycles; used only with WAIT_TIMEOUT_EN.

Ports:
- clka  in  1  system clock; all state updates on rising edge.
- restart_n  in  1  asynchronous active-low reset.
- new_game  in  1  level request to begin or restart a game.
- data_valid  in  1  user cell index available on datapath data bus.
- alu_done  in  1  from datapath.
- display_done  in  1  from datapath.
- gameover  in  1  from datapath.
- win  in  1  from datapath.
- dp_restart  out  1  datapath restart.
- dp_start  out  1  datapath start.
- dp_load  out  1  datapath load.
- dp_decode  out  1  datapath decode.
- dp_alu  out  1  datapath alu.
- dp_display  out  1  datapath display.
- in_ready  out  1  controller accepts data_valid.
- in_ack  out  1  one-cycle pulse; input consumed.
- game_active  out  1  game in progress.
- game_over_o  out  1  latched end of game.
- game_won_o  out  1  latched win.
- move_count  out  MOVE_W  moves completed this game.
- ctrl_err  out  1  watchdog fired.

Behaviour:
- Reset (restart_n=0, asynchronous):
  - state=INIT, dp_restart=1.
  - All other outputs 0, move_count=0, hold counter 0.
- Control-pulse exclusivity: dp_* outputs are one-hot or all-zero in every cycle. Each dp_* pulse lasts exactly one clka cycle.
- INIT: dp_restart=1 for one cycle -> IDLE.
- IDLE:
  - All dp_* are 0; in_ready=0.
  - new_game=1 -> START.
- START:
  - dp_start=1.
  - Clear move_count, game_over_o and game_won_o; set game_active=1.
  - -> WAIT_IN.
- WAIT_IN:
  - in_ready=1.
  - new_game=1 -> START. new_game has priority over a simultaneous data_valid; that data_valid is dropped with no in_ack.
  - Else data_valid=1 -> LOAD.
- LOAD:
  - dp_load=1 and in_ack=1, same cycle; in_ready=0.
  - The data bus must be stable during this cycle.
  - -> DECODE.
- DECODE: dp_decode=1 -> ALU.
- ALU:
  - dp_alu=1 for exactly one cycle, so the datapath score increments once per win.
  - -> ALU_WAIT.
- ALU_WAIT:
  - All dp_* are 0.
  - On alu_done=1: latch gameover and win into internal flags; move_count+1, saturating at 2^MOVE_W-1; -> DISPLAY.
- DISPLAY: dp_display=1; load hold counter with DISP_HOLD -> DISP_WAIT.
- DISP_WAIT:
  - Hold counter decrements each cycle.
  - Leaves when display_done=1 AND counter==0:
    - latched gameover=1 -> OVER.
    - Otherwise -> WAIT_IN.
- OVER:
  - game_active=0, game_over_o=1, game_won_o=latched win; both held.
  - new_game=1 -> START.
- new_game and data_valid are ignored in LOAD through DISP_WAIT. They are neither queued nor acked.
- alu_done or display_done arriving early, or in a non-wait state, has no effect.
- Reset asserted mid-sequence: immediate return to INIT values. The game is abandoned and no in_ack is issued.
- The state encoding is implementer's choice. Illegal states recover to INIT on the next edge.

Optional Feature:
- Macro: WAIT_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while in ALU_WAIT or DISP_WAIT.
  - If it reaches TIMEOUT_CYC without the exit condition: -> ERR.
  - ERR: ctrl_err=1, game_active=0, all dp_* are 0.
  - new_game=1 in ERR -> INIT, which clears ctrl_err.
- Undefined: no counter and no ERR state; the wait states wait indefinitely; ctrl_err is tied 0.

Test Plan:
- Reset, then new_game=1 -> INIT, IDLE and START each last one cycle; dp_restart then dp_start each pulse once; in_ready=1 from the following cycle.
- In WAIT_IN, data_valid=1, datapath returns alu_done=1 after 3 cycles, gameover=0, display_done=1 immediately:
  - dp_load, dp_decode and dp_alu pulse on consecutive cycles.
  - dp_display pulses 1 cycle after alu_done.
  - Return to WAIT_IN exactly DISP_HOLD+1 cycles after dp_display.
  - move_count=1.
- Move with gameover=1, win=0 -> OVER; game_over_o=1, game_won_o=0, game_active=0; data_valid ignored (no in_ack).
- Move with gameover=1, win=1 -> game_won_o=1; dp_alu high for exactly one cycle; then new_game -> START clears the flags and move_count.
- new_game and data_valid asserted together in WAIT_IN -> START taken, no in_ack; restart_n pulsed low during ALU_WAIT -> all outputs 0 asynchronously, dp_restart=1.
- WAIT_TIMEOUT_EN defined, alu_done held 0 -> ctrl_err=1 after TIMEOUT_CYC=255 cycles; new_game -> INIT, ctrl_err=0.
